// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types, LCD command codes and init table for the LCD write scheduler
package lcd_pkg;

  // Scheduler states: power-up init, waiting for work, and the three kinds of bus work
  typedef enum logic [2:0] {
    TOP_INIT,
    TOP_IDLE,
    TOP_CHAR,
    TOP_WRAP,
    TOP_CLEAR
  } top_state_e;

  // Bus timing states for one {rs,data} write
  typedef enum logic [2:0] {
    BUS_IDLE,
    BUS_SETUP,
    BUS_PULSE,
    BUS_HOLD,
    BUS_DONE
  } bus_state_e;

  localparam int         INIT_LEN      = 5;
  localparam int         LCD_COLS      = 16;
  localparam logic [8:0] LCD_CMD_CLEAR = 9'h001;
  localparam logic [8:0] LCD_CMD_LINE1 = 9'h080;
  localparam logic [8:0] LCD_CMD_LINE2 = 9'h0C0;

  // Power-up command table as {rs,data}: 8-bit 2-line, display on, clear, entry mode, home
  function automatic logic [8:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    init_cmd = 9'h038;
      3'd1:    init_cmd = 9'h00C;
      3'd2:    init_cmd = 9'h001;
      3'd3:    init_cmd = 9'h006;
      default: init_cmd = 9'h080;
    endcase
  endfunction

endpackage

// File: rtl/lcd_char_fifo.sv
// rtl/lcd_char_fifo.sv - small synchronous FIFO buffering characters ahead of the LCD bus
module lcd_char_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage array needs no reset; only the pointers define what is valid
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

  // Pointer and occupancy tracking; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/lcd_write_sched.sv
// rtl/lcd_write_sched.sv - LCD bus owner: init sequence, char FIFO, auto wrap/clear, EN/RS timing
module lcd_write_sched
  import lcd_pkg::*;
#(
  parameter int PAYLOAD_BITS = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int EN_PULSE_CYC = 24,
  parameter int CMD_WAIT_CYC = 82433
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [PAYLOAD_BITS-1:0] char_data_i,
  input  logic                    char_valid_i,
  output logic                    char_ready_o,
  input  logic                    clr_req_i,
  output logic [PAYLOAD_BITS-1:0] lcd_data_o,
  output logic                    lcd_rs_o,
  output logic                    lcd_rw_o,
  output logic                    lcd_en_o,
  output logic                    init_done_o,
  output logic                    busy_o
);

  localparam int WW      = PAYLOAD_BITS + 1;
  localparam int CNT_MAX = (EN_PULSE_CYC > CMD_WAIT_CYC) ? EN_PULSE_CYC : CMD_WAIT_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  top_state_e              top_q;
  bus_state_e              bus_q;
  logic [CW-1:0]           cnt_q;
  logic [WW-1:0]           word_q;
  logic [2:0]              init_idx_q;
  logic [4:0]              col_q;
  logic                    clr_pend_q;
  logic                    clr_step_q;
  logic                    init_done_q;
  logic                    busy_q;

  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [PAYLOAD_BITS-1:0] fifo_head;
  logic                    bus_start;
  logic [WW-1:0]           bus_word;
  logic                    bus_done;

  assign char_ready_o = !fifo_full && init_done_q;
  assign fifo_push    = char_valid_i && char_ready_o;
  assign fifo_pop     = (top_q == TOP_CHAR) && (bus_q == BUS_SETUP);
  assign bus_done     = (bus_q == BUS_DONE);

  assign lcd_data_o  = word_q[PAYLOAD_BITS-1:0];
  assign lcd_rs_o    = word_q[PAYLOAD_BITS];
  assign lcd_rw_o    = 1'b0;
  assign lcd_en_o    = (bus_q == BUS_PULSE);
  assign init_done_o = init_done_q;
  assign busy_o      = busy_q;

  lcd_char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PAYLOAD_BITS)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (fifo_push),
    .data_i  (char_data_i),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Pick the next bus write whenever the bus is free; clear-pending outranks queued chars
  always_comb begin
    bus_start = 1'b0;
    bus_word  = '0;
    if (bus_q == BUS_IDLE) begin
      case (top_q)
        TOP_INIT: begin
          bus_start = 1'b1;
          bus_word  = WW'(init_cmd(init_idx_q));
        end
        TOP_IDLE: begin
          if (clr_pend_q) begin
            bus_start = 1'b1;
            bus_word  = WW'(LCD_CMD_CLEAR);
          end else if (!fifo_empty) begin
            bus_start = 1'b1;
            bus_word  = {1'b1, fifo_head};
          end
        end
        TOP_WRAP: begin
          bus_start = 1'b1;
          bus_word  = (col_q == 5'd0) ? WW'(LCD_CMD_LINE1) : WW'(LCD_CMD_LINE2);
        end
        TOP_CLEAR: begin
          bus_start = 1'b1;
          bus_word  = clr_step_q ? WW'(LCD_CMD_LINE1) : WW'(LCD_CMD_CLEAR);
        end
        default: begin
          bus_start = 1'b0;
        end
      endcase
    end
  end

  // Bus timing: SETUP, EN pulse, hold-off wait, DONE; data/RS latched for the whole write
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bus_q  <= BUS_IDLE;
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      case (bus_q)
        BUS_IDLE: begin
          if (bus_start) begin
            bus_q  <= BUS_SETUP;
            word_q <= bus_word;
          end
        end
        BUS_SETUP: begin
          bus_q <= BUS_PULSE;
          cnt_q <= '0;
        end
        BUS_PULSE: begin
          if (cnt_q == CW'(EN_PULSE_CYC - 1)) begin
            bus_q <= BUS_HOLD;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        BUS_HOLD: begin
          if (cnt_q == CW'(CMD_WAIT_CYC - 1)) begin
            bus_q <= BUS_DONE;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: bus_q <= BUS_IDLE;
      endcase
    end
  end

  // Scheduler: walks init table, then serves clears, chars and automatic line wraps
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      top_q       <= TOP_INIT;
      init_idx_q  <= '0;
      col_q       <= '0;
      clr_pend_q  <= 1'b0;
      clr_step_q  <= 1'b0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      busy_q     <= (top_q != TOP_IDLE) || !fifo_empty || clr_pend_q;
      clr_pend_q <= clr_req_i || (clr_pend_q && !(top_q == TOP_IDLE && bus_start));
      case (top_q)
        TOP_INIT: begin
          if (bus_done) begin
            if (init_idx_q == 3'(INIT_LEN - 1)) begin
              top_q       <= TOP_IDLE;
              init_done_q <= 1'b1;
            end else begin
              init_idx_q <= init_idx_q + 3'd1;
            end
          end
        end
        TOP_IDLE: begin
          if (bus_start) begin
            top_q      <= clr_pend_q ? TOP_CLEAR : TOP_CHAR;
            clr_step_q <= 1'b0;
          end
        end
        TOP_CHAR: begin
          if (bus_done) begin
            col_q <= col_q + 5'd1;
            if (col_q == 5'(LCD_COLS - 1) || col_q == 5'd31) top_q <= TOP_WRAP;
            else                                              top_q <= TOP_IDLE;
          end
        end
        TOP_WRAP: begin
          if (bus_done) top_q <= TOP_IDLE;
        end
        TOP_CLEAR: begin
          if (bus_done) begin
            if (clr_step_q) begin
              top_q <= TOP_IDLE;
              col_q <= '0;
            end else begin
              clr_step_q <= 1'b1;
            end
          end
        end
        default: top_q <= TOP_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_write_sched.sv
// tb/tb_lcd_write_sched.sv - self-checking bench for lcd_write_sched with short bus timing
module tb_lcd_write_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] char_data_i = 8'h00;
  logic       char_valid_i = 1'b0;
  logic       char_ready_o;
  logic       clr_req_i = 1'b0;
  logic [7:0] lcd_data_o;
  logic       lcd_rs_o;
  logic       lcd_rw_o;
  logic       lcd_en_o;
  logic       init_done_o;
  logic       busy_o;

  always #5 clk = ~clk;

  lcd_write_sched #(
    .PAYLOAD_BITS (8),
    .FIFO_DEPTH   (4),
    .EN_PULSE_CYC (2),
    .CMD_WAIT_CYC (4)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .char_data_i  (char_data_i),
    .char_valid_i (char_valid_i),
    .char_ready_o (char_ready_o),
    .clr_req_i    (clr_req_i),
    .lcd_data_o   (lcd_data_o),
    .lcd_rs_o     (lcd_rs_o),
    .lcd_rw_o     (lcd_rw_o),
    .lcd_en_o     (lcd_en_o),
    .init_done_o  (init_done_o),
    .busy_o       (busy_o)
  );

  typedef struct {
    string      name;
    bit         do_clr;
    logic [7:0] first;
    int         n;
    int         exp_cnt;
    logic [8:0] exp_last;
  } row_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [8:0] wr_q[$];
  int         pw_q[$];
  logic [8:0] exp_q[$];
  logic       prev_en = 1'b0;
  int         en_cnt = 0;
  int         col_m = 0;
  row_t       rows[5];
  logic [8:0] exp_init[5];
  logic [8:0] exp_clr[5];

  // Bus monitor: logs each write at its EN rising edge and the EN-high width of each pulse
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en = 1'b0;
      en_cnt  = 0;
    end else begin
      if (lcd_en_o && !prev_en) wr_q.push_back({lcd_rs_o, lcd_data_o});
      if (lcd_en_o) en_cnt++;
      else if (en_cnt > 0) begin
        pw_q.push_back(en_cnt);
        en_cnt = 0;
      end
      prev_en = lcd_en_o;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge
  task automatic push_char(input logic [7:0] ch);
    int guard;
    guard = 0;
    char_data_i  = ch;
    char_valid_i = 1'b1;
    while (!char_ready_o && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 400) check("push_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    char_valid_i = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_req_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr_req_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    repeat (2) @(negedge clk);
    while ((busy_o || lcd_en_o) && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("idle_timeout", 32'(i < budget), 32'd1);
  endtask

  task automatic wait_init(input int budget, output bit ready_seen);
    int i;
    i = 0;
    ready_seen = 1'b0;
    while (!init_done_o && i < budget) begin
      @(negedge clk);
      if (char_ready_o && !init_done_o) ready_seen = 1'b1;
      i++;
    end
    check("init_timeout", 32'(i < budget), 32'd1);
  endtask

  task automatic check_init_writes(input string tag);
    check({tag, "_count"}, 32'(wr_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < wr_q.size(); i++)
      check({tag, "_word"}, 32'(wr_q[i]), 32'(exp_init[i]));
  endtask

  initial begin
    bit ready_seen;
    int idx, run, guard;
    bit dropped;

    exp_init = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h080};
    exp_clr  = '{9'h151, 9'h001, 9'h080, 9'h152, 9'h153};
    rows[0]  = '{"one_char",   1'b0, 8'h41, 1,  1,  9'h141};
    rows[1]  = '{"clear",      1'b1, 8'h00, 0,  2,  9'h080};
    rows[2]  = '{"line1_fill", 1'b0, 8'h30, 16, 17, 9'h0C0};
    rows[3]  = '{"line2_fill", 1'b0, 8'h40, 16, 17, 9'h080};
    rows[4]  = '{"after_wrap", 1'b0, 8'h61, 3,  3,  9'h163};

    // Reset state
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          32'({lcd_en_o, lcd_rs_o, lcd_rw_o, lcd_data_o, init_done_o, char_ready_o, busy_o}),
          32'd0);

    // Power-up init sequence
    rst_n = 1'b1;
    wait_init(300, ready_seen);
    check("init_ready_low", 32'(ready_seen), 32'd0);
    check_init_writes("init");
    check("init_pw_count", 32'(pw_q.size()), 32'd5);
    foreach (pw_q[i]) check("init_en_width", 32'(pw_q[i]), 32'd2);
    check("init_rw", 32'(lcd_rw_o), 32'd0);
    wr_q.delete();
    pw_q.delete();

    // Character, clear and wrap sequences from the table
    col_m = 0;
    foreach (rows[r]) begin
      exp_q.delete();
      if (rows[r].do_clr) begin
        pulse_clr();
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h080);
        col_m = 0;
      end
      for (int k = 0; k < rows[r].n; k++) begin
        push_char(8'(rows[r].first + 8'(k)));
        exp_q.push_back({1'b1, 8'(rows[r].first + 8'(k))});
        col_m++;
        if (col_m == 16) exp_q.push_back(9'h0C0);
        if (col_m == 32) begin
          exp_q.push_back(9'h080);
          col_m = 0;
        end
      end
      wait_idle(800);
      check({rows[r].name, "_count"}, 32'(wr_q.size()), 32'(rows[r].exp_cnt));
      if (wr_q.size() > 0)
        check({rows[r].name, "_last"}, 32'(wr_q[wr_q.size()-1]), 32'(rows[r].exp_last));
      for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
        check({rows[r].name, "_word"}, 32'(wr_q[i]), 32'(exp_q[i]));
      check({rows[r].name, "_busy"}, 32'(busy_o), 32'd0);
      wr_q.delete();
    end

    // Backpressure: valid held with 6 chars from idle; ready must drop after 5 accepts
    idx = 0; run = 0; guard = 0; dropped = 1'b0;
    char_valid_i = 1'b1;
    while (idx < 6 && guard < 500) begin
      char_data_i = 8'(8'h70 + 8'(idx));
      if (char_ready_o) begin
        @(posedge clk);
        idx++;
        if (!dropped) run++;
      end else begin
        dropped = 1'b1;
        @(posedge clk);
      end
      @(negedge clk);
      guard++;
    end
    char_valid_i = 1'b0;
    check("bp_accept_before_full", 32'(run), 32'd5);
    check("bp_ready_dropped", 32'(dropped), 32'd1);
    wait_idle(400);
    check("bp_count", 32'(wr_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < wr_q.size(); i++)
      check("bp_order", 32'(wr_q[i]), 32'(9'h170 + 9'(i)));
    wr_q.delete();

    // Clear requested twice while a char is on the bus with two more queued
    push_char(8'h51);
    push_char(8'h52);
    push_char(8'h53);
    guard = 0;
    while (!lcd_en_o && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("clr_saw_pulse", 32'(lcd_en_o), 32'd1);
    pulse_clr();
    pulse_clr();
    wait_idle(400);
    check("clr_count", 32'(wr_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < wr_q.size(); i++)
      check("clr_word", 32'(wr_q[i]), 32'(exp_clr[i]));
    wr_q.delete();
    // Column resumed at 2: 14 more chars land exactly at the line-2 wrap
    for (int k = 0; k < 14; k++) push_char(8'(8'h20 + 8'(k)));
    wait_idle(600);
    check("clr_col_count", 32'(wr_q.size()), 32'd15);
    if (wr_q.size() == 15) begin
      check("clr_col_last_char", 32'(wr_q[13]), 32'h12D);
      check("clr_col_wrap", 32'(wr_q[14]), 32'h0C0);
    end
    wr_q.delete();

    // Asynchronous reset in the middle of an EN pulse
    push_char(8'h77);
    push_char(8'h78);
    guard = 0;
    while (!lcd_en_o && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("rst_saw_pulse", 32'(lcd_en_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_outputs",
          32'({lcd_en_o, lcd_rs_o, lcd_data_o, init_done_o, char_ready_o, busy_o}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    wr_q.delete();
    pw_q.delete();
    rst_n = 1'b1;
    wait_init(300, ready_seen);
    check("reinit_ready_low", 32'(ready_seen), 32'd0);
    check_init_writes("reinit");
    wait_idle(200);
    check("rst_fifo_flushed", 32'(wr_q.size()), 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
